// File: rtl/rv_dmem_responder.sv
// rv_dmem_responder: RV32I load/store responder with byte-lane memory and programmable wait states.
// Optional macro DMEM_STORE_READBACK_EN: successful stores return the post-write word on rdata.
module rv_dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic a_we;
  logic [2:0] a_f3;
  logic [31:0] a_addr, a_wdata;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] word, sh, ld, wd, merged, rdata_nxt;
  logic [3:0] be;
  logic flt, access, wr;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata   <= '0;
      fault   <= 1'b0;
      a_we    <= 1'b0;
      a_f3    <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fault <= access && flt;
      if (access) rdata <= rdata_nxt;
      if (state == IDLE && req) begin
        a_we    <= we;
        a_f3    <= funct3;
        a_addr  <= addr;
        a_wdata <= wdata;
      end
    end

  always_ff @(posedge clk)
    if (wr) mem[a_addr[ADDR_WIDTH+1:2]] <= merged;

  always_comb begin
    access    = state == WAIT && cnt == '0;
    state_nxt = state == IDLE ? (req ? WAIT : IDLE) : state == WAIT ? (access ? RESP : WAIT) : IDLE;
    cnt_nxt   = (state == IDLE && req) ? 8'(WAIT_CYCLES) : (state == WAIT && cnt != '0) ? cnt - 8'd1 : cnt;
    ready     = state == RESP;
    busy      = state != IDLE;
  end

  // All checks look at the captured request, never the live inputs.
  always_comb begin
    flt = a_f3 == 3'b011 || a_f3[2:1] == 2'b11
       || (a_we && a_f3[2])
       || (a_f3[1:0] == 2'b01 && a_addr[0])
       || (a_f3 == 3'b010 && a_addr[1:0] != 2'b00)
       || |a_addr[31:ADDR_WIDTH+2];
    wr   = access && a_we && !flt;
    word = mem[a_addr[ADDR_WIDTH+1:2]];
    sh   = word >> {a_addr[1:0], 3'b000};
    ld   = a_f3[1] ? sh
         : a_f3[0] ? {{16{~a_f3[2] & sh[15]}}, sh[15:0]}
         : {{24{~a_f3[2] & sh[7]}}, sh[7:0]};
    wd   = a_f3[1] ? a_wdata : a_f3[0] ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
    be   = a_f3[1] ? 4'hf : a_f3[0] ? (a_addr[1] ? 4'hc : 4'h3) : 4'b0001 << a_addr[1:0];
    merged = word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i+:8] = wd[8*i+:8];
`ifdef DMEM_STORE_READBACK_EN
    rdata_nxt = flt ? '0 : a_we ? merged : ld;
`else
    rdata_nxt = flt ? '0 : a_we ? '0 : ld;
`endif
  end
endmodule
